change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Pays out the vending core's change amount as physical coins, sitting between
//    the core's dispense/change outputs and the coin-hopper driver.
//  Accepts one change amount (cents) per transaction.
//  Decomposes it greedily into 25/10/5-cent coins.
//  Emits one eject pulse per coin, paced by hopper ready and a minimum inter-coin gap.
// PARAMETERS
//  GAP_CYCLES  16  idle clocks enforced after each eject pulse (0 = back-to-back allowed)
//  AMT_W       8   width of change amount in cents
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      asynchronous, active-high reset
//  change_valid  in   1      change amount offered (tie to core dispense)
//  change        in   AMT_W  change amount in cents
//  change_ready  out  1      1 = idle, new amount will be accepted
//  hopper_ready  in   1      hopper can take an eject command this cycle
//  eject_25      out  1      one-cycle pulse: eject one 25c coin
//  eject_10      out  1      one-cycle pulse: eject one 10c coin
//  eject_5       out  1      one-cycle pulse: eject one 5c coin
//  pay_done      out  1      one-cycle pulse: transaction finished
//  short_pay     out  1      valid with pay_done: residue <5c could not be paid
//  tally_25/10/5 out  16 ea  [COIN_TALLY_EN only] saturating coins-ejected counters
// BEHAVIOUR
//  Reset values:
//    - All outputs 0 except change_ready = 1.
//    - State IDLE, remainder 0.
//    - Tallies 0.
//  States: IDLE -> PAY -> (GAP -> PAY)* -> DONE -> IDLE.
//  IDLE:
//    - change_ready = 1.
//    - change_valid = 1: latch change into remainder, go to PAY next edge.
//  PAY, remainder < 5: go to DONE.
//  PAY, hopper_ready = 0: stall in PAY, no pulse.
//  PAY, hopper_ready = 1: pick largest coin <= remainder (25, else 10, else 5).
//    - Subtract it from remainder.
//    - Register the matching eject_* high for exactly the next cycle.
//    - Go to GAP, or stay in PAY if GAP_CYCLES == 0.
//  GAP:
//    - Down-counter loaded with GAP_CYCLES-1.
//    - Return to PAY when it reaches 0.
//    - hopper_ready is ignored during GAP.
//  DONE: pay_done = 1 for one cycle.
//    - short_pay = (remainder != 0) in the same cycle.
//    - Then IDLE; change_ready rises the following cycle.
//  Exclusivity:
//    - At most one eject_* high in any cycle.
//    - Pulses never adjacent unless GAP_CYCLES == 0.
//  Busy:
//    - change_valid while not IDLE is ignored; no queueing.
//    - A change that arrives while busy is lost; upstream must hold it until change_ready.
//  Zero amount: IDLE -> PAY -> DONE, no ejects, short_pay = 0.
//  Arithmetic: remainder is AMT_W bits unsigned; subtraction only when coin <= remainder,
//    so it never wraps.
//  Latency: first eject pulse 2 cycles after accept if hopper_ready is held high.
//  Reset mid-transaction:
//    - Immediate abort to IDLE, remainder cleared, any pending pulse dropped.
//    - No pay_done.
// CONFIGURATION
//  COIN_TALLY_EN defined:
//    - tally_25/tally_10/tally_5 ports exist.
//    - Each increments on its eject pulse and saturates at 16'hFFFF.
//    - Cleared only by reset.
//  COIN_TALLY_EN undefined:
//    - Tally ports and counters absent.
//    - Payout behaviour identical.
// STRUCTURE
//  retro_vend_pkg:
//    - Coin value localparams COIN_5/COIN_10/COIN_25.
//    - typedef enum logic [1:0] {CD_IDLE, CD_PAY, CD_GAP, CD_DONE} cd_state_t.
//  Sub-module change_gap_timer:
//    - Loadable down-counter, GAP_CYCLES wide enough.
//    - load and expired ports.
//  Everything else is inline in change_dispenser.
// TESTING
//  1. change=40, hopper_ready=1, GAP=16: eject_25, eject_10, eject_5 in order,
//     pulses 17 clocks apart; pay_done with short_pay=0.
//  2. change=0: pay_done 2 cycles after accept, no eject pulses, short_pay=0.
//  3. change=7: single eject_5, then pay_done with short_pay=1.
//  4. change=255: ten eject_25 then one eject_5; short_pay=0.
//     [COIN_TALLY_EN] tally_25=10, tally_5=1.
//  5. change=30, hopper_ready low 50 cycles: no pulse while low;
//     eject_25 the cycle after it rises; change_valid during payout ignored.
//  6. change=60, reset asserted after first eject_25: all outputs reset,
//     no pay_done; change_ready=1 next cycle after reset release.

Source files
------------

// File: rtl/retro_vend_pkg.sv
// ---------------------------------------------------------------------------
// retro_vend_pkg
//   Shared definitions for the vending change path.
//   - COIN_5 / COIN_10 / COIN_25 : coin values in cents
//   - cd_state_t                 : change_dispenser FSM state encoding
// ---------------------------------------------------------------------------
package retro_vend_pkg;

    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;
    localparam int COIN_25 = 25;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_PAY,
        CD_GAP,
        CD_DONE
    } cd_state_t;

endpackage : retro_vend_pkg

// File: rtl/change_gap_timer.sv
// ---------------------------------------------------------------------------
// change_gap_timer
//   Loadable down-counter that times the idle gap between coin ejects.
//   Ports:
//     clk      in   system clock
//     reset    in   asynchronous active-high reset (count cleared)
//     load     in   load load_val this cycle (takes priority over counting)
//     load_val in   CNT_W  value to load
//     expired  out  count is zero
//   The count decrements every cycle it is non-zero and holds at zero.
// ---------------------------------------------------------------------------
module change_gap_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule : change_gap_timer

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//   Pays a change amount (cents) out as 25/10/5-cent coins, largest first,
//   one eject pulse per coin, paced by hopper_ready and a minimum gap of
//   GAP_CYCLES idle clocks after each pulse.
//
//   Parameters:
//     GAP_CYCLES  idle clocks after each eject pulse (0 = back-to-back)
//     AMT_W       width of the change amount in cents (must be >= 5)
//
//   Ports:
//     clk           in   system clock
//     reset         in   asynchronous active-high reset
//     change_valid  in   change amount offered
//     change        in   AMT_W  change amount in cents
//     change_ready  out  idle; an offered amount is accepted this cycle
//     hopper_ready  in   hopper can take an eject command this cycle
//     eject_25/10/5 out  one-cycle eject pulse per coin
//     pay_done      out  one-cycle pulse: transaction finished
//     short_pay     out  with pay_done: a residue below 5c was left unpaid
//     tally_25/10/5 out  16-bit saturating coin counters (COIN_TALLY_EN only)
//     state_dbg     out  current FSM state
//
//   Handshake: an amount is taken on a rising edge where change_valid and
//   change_ready are both high. change_valid while busy is ignored, not
//   queued; upstream must hold the amount until change_ready.
//
//   Build option: define COIN_TALLY_EN to add the tally counters and ports.
// ---------------------------------------------------------------------------
module change_dispenser
    import retro_vend_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int AMT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change,
    output logic             change_ready,
    input  logic             hopper_ready,
    output logic             eject_25,
    output logic             eject_10,
    output logic             eject_5,
    output logic             pay_done,
    output logic             short_pay,
`ifdef COIN_TALLY_EN
    output logic [15:0]      tally_25,
    output logic [15:0]      tally_10,
    output logic [15:0]      tally_5,
`endif
    output cd_state_t        state_dbg
);

    // GAP_CYCLES-1 is the largest value the timer ever holds.
    localparam int               CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    localparam logic [AMT_W-1:0] C5  = AMT_W'(COIN_5);
    localparam logic [AMT_W-1:0] C10 = AMT_W'(COIN_10);
    localparam logic [AMT_W-1:0] C25 = AMT_W'(COIN_25);

    cd_state_t        state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             change_ready_q, change_ready_d;
    logic             eject_25_q, eject_25_d;
    logic             eject_10_q, eject_10_d;
    logic             eject_5_q, eject_5_d;
    logic             pay_done_q, pay_done_d;
    logic             short_pay_q, short_pay_d;
    logic             gap_load;
    logic             gap_expired;

    change_gap_timer #(
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .expired  (gap_expired)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        eject_25_d  = 1'b0;
        eject_10_d  = 1'b0;
        eject_5_d   = 1'b0;
        pay_done_d  = 1'b0;
        short_pay_d = 1'b0;
        gap_load    = 1'b0;

        case (state_q)
            CD_IDLE: begin
                if (change_valid) begin
                    rem_d   = change;
                    state_d = CD_PAY;
                end
            end

            CD_PAY: begin
                // Residue check comes first so a finished payout never
                // waits on the hopper.
                if (rem_q < C5) begin
                    state_d     = CD_DONE;
                    pay_done_d  = 1'b1;
                    short_pay_d = (rem_q != '0);
                end else if (hopper_ready) begin
                    if (rem_q >= C25) begin
                        eject_25_d = 1'b1;
                        rem_d      = rem_q - C25;
                    end else if (rem_q >= C10) begin
                        eject_10_d = 1'b1;
                        rem_d      = rem_q - C10;
                    end else begin
                        eject_5_d  = 1'b1;
                        rem_d      = rem_q - C5;
                    end
                    // Timer loads on the same edge the pulse is registered,
                    // so the GAP state spans exactly GAP_CYCLES clocks.
                    gap_load = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = CD_PAY;
                    end else begin
                        state_d = CD_GAP;
                    end
                end
            end

            CD_GAP: begin
                if (gap_expired) begin
                    state_d = CD_PAY;
                end
            end

            CD_DONE: begin
                state_d = CD_IDLE;
            end

            default: begin
                state_d = CD_IDLE;
            end
        endcase

        change_ready_d = (state_d == CD_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= CD_IDLE;
            rem_q          <= '0;
            change_ready_q <= 1'b1;
            eject_25_q     <= 1'b0;
            eject_10_q     <= 1'b0;
            eject_5_q      <= 1'b0;
            pay_done_q     <= 1'b0;
            short_pay_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            change_ready_q <= change_ready_d;
            eject_25_q     <= eject_25_d;
            eject_10_q     <= eject_10_d;
            eject_5_q      <= eject_5_d;
            pay_done_q     <= pay_done_d;
            short_pay_q    <= short_pay_d;
        end
    end

`ifdef COIN_TALLY_EN
    logic [15:0] tally_25_q, tally_25_d;
    logic [15:0] tally_10_q, tally_10_d;
    logic [15:0] tally_5_q,  tally_5_d;

    // Count on the registered pulse so the tally matches what the hopper saw.
    always_comb begin
        tally_25_d = tally_25_q;
        tally_10_d = tally_10_q;
        tally_5_d  = tally_5_q;
        if (eject_25_q && (tally_25_q != 16'hFFFF)) tally_25_d = tally_25_q + 16'd1;
        if (eject_10_q && (tally_10_q != 16'hFFFF)) tally_10_d = tally_10_q + 16'd1;
        if (eject_5_q  && (tally_5_q  != 16'hFFFF)) tally_5_d  = tally_5_q  + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tally_25_q <= '0;
            tally_10_q <= '0;
            tally_5_q  <= '0;
        end else begin
            tally_25_q <= tally_25_d;
            tally_10_q <= tally_10_d;
            tally_5_q  <= tally_5_d;
        end
    end

    assign tally_25 = tally_25_q;
    assign tally_10 = tally_10_q;
    assign tally_5  = tally_5_q;
`endif

    assign change_ready = change_ready_q;
    assign eject_25     = eject_25_q;
    assign eject_10     = eject_10_q;
    assign eject_5      = eject_5_q;
    assign pay_done     = pay_done_q;
    assign short_pay    = short_pay_q;
    assign state_dbg    = state_q;

endmodule : change_dispenser

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//   Self-checking bench for change_dispenser (GAP_CYCLES = 16, AMT_W = 8).
//   Expected output events (one-hot coin or pay_done with short flag) are
//   queued when an amount is driven and compared as the DUT emits them.
//   Event spacing is checked against the accept cycle / previous event.
//   Define COIN_TALLY_EN to also check the tally counters.
// ---------------------------------------------------------------------------
module tb_change_dispenser;
    import retro_vend_pkg::*;

    localparam int GAP   = 16;
    localparam int AMT_W = 8;
    localparam int EV_W  = 5;

    // Event encoding: {short, done, e25, e10, e5}
    localparam logic [EV_W-1:0] EV_25 = 5'b00100;
    localparam logic [EV_W-1:0] EV_10 = 5'b00010;
    localparam logic [EV_W-1:0] EV_5  = 5'b00001;
    localparam logic [EV_W-1:0] EV_OK = 5'b01000;
    localparam logic [EV_W-1:0] EV_SH = 5'b11000;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             change_valid = 1'b0;
    logic [AMT_W-1:0] change = '0;
    logic             hopper_ready = 1'b1;
    logic             change_ready;
    logic             eject_25, eject_10, eject_5;
    logic             pay_done, short_pay;
    cd_state_t        state_dbg;
`ifdef COIN_TALLY_EN
    logic [15:0]      tally_25, tally_10, tally_5;
    int               m25 = 0, m10 = 0, m5 = 0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    change_dispenser #(
        .GAP_CYCLES (GAP),
        .AMT_W      (AMT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .change_valid (change_valid),
        .change       (change),
        .change_ready (change_ready),
        .hopper_ready (hopper_ready),
        .eject_25     (eject_25),
        .eject_10     (eject_10),
        .eject_5      (eject_5),
        .pay_done     (pay_done),
        .short_pay    (short_pay),
`ifdef COIN_TALLY_EN
        .tally_25     (tally_25),
        .tally_10     (tally_10),
        .tally_5      (tally_5),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EV_W-1:0] exp_q[$];

    int prev_cyc    = 0;  // cycle of accept or previous event
    int first_delta = 2;  // expected distance to the first event
    int n_ev        = 0;  // events seen in the current transaction
    bit lat_check   = 1'b0;
    bit txn_done    = 1'b0;

    task automatic push_exp(input int amt);
        int r;
        r = amt;
        while (r >= 25) begin exp_q.push_back(EV_25); r -= 25;
`ifdef COIN_TALLY_EN
            m25++;
`endif
        end
        while (r >= 10) begin exp_q.push_back(EV_10); r -= 10;
`ifdef COIN_TALLY_EN
            m10++;
`endif
        end
        while (r >= 5) begin exp_q.push_back(EV_5); r -= 5;
`ifdef COIN_TALLY_EN
            m5++;
`endif
        end
        exp_q.push_back((r != 0) ? EV_SH : EV_OK);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [EV_W-1:0] ev;
        logic [EV_W-1:0] exp;
        if (!reset) begin
            ev = {pay_done & short_pay, pay_done, eject_25, eject_10, eject_5};
            if (short_pay && !pay_done) check_eq("short_without_done", 32'(short_pay), 32'd0);
            if (ev != '0) begin
                check_eq("one_hot", 32'($countones(ev[2:0]) <= 1), 32'd1);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", 32'(ev), 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check_eq("event", 32'(ev), 32'(exp));
                end
                if (lat_check) begin
                    check_eq("spacing", 32'(cyc - prev_cyc), (n_ev == 0) ? 32'(first_delta) : 32'(GAP + 1));
                end else if (n_ev != 0) begin
                    check_eq("min_gap", 32'((cyc - prev_cyc) >= GAP + 1), 32'd1);
                end
                prev_cyc = cyc;
                n_ev++;
                if (pay_done) txn_done = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int k;
        k = 0;
        while (!change_ready && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("ready_timeout", 32'(change_ready), 32'd1);
    endtask

    // Offer an amount for one cycle; the monitor spacing is measured from it.
    task automatic offer(input int amt);
        @(negedge clk); #1;
        change_valid = 1'b1;
        change       = AMT_W'(amt);
        prev_cyc     = cyc;
        first_delta  = 2;
        n_ev         = 0;
        txn_done     = 1'b0;
        @(negedge clk); #1;
        change_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_hop);
        int k;
        k = 0;
        while (!txn_done && k < 3000) begin
            if (rnd_hop) hopper_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            k++;
        end
        hopper_ready = 1'b1;
        check_eq("done_timeout", 32'(txn_done), 32'd1);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef COIN_TALLY_EN
        check_eq("tally_25", 32'(tally_25), 32'(m25));
        check_eq("tally_10", 32'(tally_10), 32'(m10));
        check_eq("tally_5",  32'(tally_5),  32'(m5));
`endif
    endtask

    task automatic pay(input int amt, input bit rnd_hop);
        wait_ready();
        push_exp(amt);
        lat_check = !rnd_hop;
        offer(amt);
        wait_done(rnd_hop);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_eq("rst_change_ready", 32'(change_ready), 32'd1);
        check_eq("rst_ejects", 32'({eject_25, eject_10, eject_5}), 32'd0);
        check_eq("rst_pay_done", 32'({pay_done, short_pay}), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(CD_IDLE));
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_ready", 32'(change_ready), 32'd1);

        // Directed: mixed coins, zero, short residue, maximum amount.
        pay(40, 1'b0);
        pay(0, 1'b0);
        pay(7, 1'b0);
        pay(255, 1'b0);

        // Hopper held off for 50 cycles; busy offers must be ignored.
        wait_ready();
        push_exp(30);
        hopper_ready = 1'b0;
        lat_check    = 1'b0;
        offer(30);
        change_valid = 1'b1;
        change       = 8'd99;
        check_eq("busy_not_ready", 32'(change_ready), 32'd0);
        repeat (49) begin @(negedge clk); #1; end
        change_valid = 1'b0;
        check_eq("stall_no_pulse", 32'(n_ev), 32'd0);
        hopper_ready = 1'b1;
        prev_cyc     = cyc;
        first_delta  = 1;
        lat_check    = 1'b1;
        @(negedge clk); #1;
        change_valid = 1'b1;
        change       = 8'd45;
        repeat (5) begin @(negedge clk); #1; end
        change_valid = 1'b0;
        wait_done(1'b0);

        // Random amounts, hopper steady then toggling.
        repeat (3) pay(int'($urandom_range(0, 255)), 1'b0);
        repeat (3) pay(int'($urandom_range(0, 255)), 1'b1);

        // Reset after the first coin of 60c: payout aborts, no pay_done.
        wait_ready();
        exp_q.push_back(EV_25);
`ifdef COIN_TALLY_EN
        m25++;
`endif
        lat_check = 1'b1;
        offer(60);
        k = 0;
        while (n_ev == 0 && k < 100) begin @(negedge clk); #1; k++; end
        check_eq("first_coin_seen", 32'(n_ev), 32'd1);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check_eq("abort_ejects", 32'({eject_25, eject_10, eject_5}), 32'd0);
        check_eq("abort_done", 32'({pay_done, short_pay}), 32'd0);
        check_eq("abort_state", 32'(state_dbg), 32'(CD_IDLE));
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
`ifdef COIN_TALLY_EN
        m25 = 0; m10 = 0; m5 = 0;
        check_eq("tally_cleared", 32'({tally_25, tally_10, tally_5} != '0), 32'd0);
`endif
        @(negedge clk); #1;
        check_eq("ready_after_reset", 32'(change_ready), 32'd1);
        txn_done = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check_eq("no_done_after_abort", 32'(txn_done), 32'd0);
        check_eq("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_change_dispenser
